// File: rtl/mctl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM and the datapath blocks it steers.
package mctl_pkg;

  localparam int unsigned StateW = 4;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  typedef enum logic [StateW-1:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StIExec   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12,
    StHalt    = 4'd15
  } state_e;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluImm   = 2'b11;

  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcVector = 2'b11;

  // ANDI/ORI treat the immediate as unsigned.
  function automatic logic is_logical_imm(input logic [5:0] op);
    return (op == OpAndi) || (op == OpOri);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpSlti, OpAndi, OpOri: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mctl_wait_timer.sv
// Counts consecutive stalled cycles in a memory state and flags the cycle that hits the limit.
module mctl_wait_timer #(
  parameter int unsigned WaitLimit = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic waiting_i,
  output logic limit_o
);

  localparam int unsigned CntW = $clog2(WaitLimit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Any cycle that is not a stall (ready, or a non-memory state) restarts the count.
  always_comb begin
    cnt_d = waiting_i ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = waiting_i && (cnt_q == CntW'(WaitLimit - 1));

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the 32-bit multi-cycle MIPS datapath.
// Define MCTL_ILLEGAL_TRAP_EN to trap unknown opcodes through TRAP and the illegal_op output.
module multicycle_control
  import mctl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned OP_W       = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mdr_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            ext_sel,
  output logic            mem_timeout,
  output logic            instr_done
`ifdef MCTL_ILLEGAL_TRAP_EN
  ,
  output logic            illegal_op
`endif
);

  state_e state_q, state_d;
  logic   mem_timeout_q, mem_timeout_d;
  logic   waiting, limit_hit;

  // The branch condition is applied in the datapath; the FSM never looks at it.
  logic unused_zero;
  assign unused_zero = zero;

  assign waiting = (state_q inside {StFetch, StMemRd, StMemWr}) && !mem_ready;

  mctl_wait_timer #(
    .WaitLimit (WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .waiting_i (waiting),
    .limit_o   (limit_hit)
  );

  always_comb begin
    state_d       = state_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:                      state_d = StMemAddr;
          OpRtype:                         state_d = StRExec;
          OpAddi, OpSlti, OpAndi, OpOri:   state_d = StIExec;
          OpBeq:                           state_d = StBranch;
          OpJ:                             state_d = StJump;
`ifdef MCTL_ILLEGAL_TRAP_EN
          default:                         state_d = StTrap;
`else
          default:                         state_d = StFetch;
`endif
        endcase
      end
      StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StRExec:   state_d = StRWb;
      StIExec:   state_d = StIWb;
      StHalt:    state_d = StHalt;
      default:   state_d = StFetch;
    endcase
    // A ready in the limit cycle clears waiting, so it naturally wins over the fault.
    if (limit_hit) begin
      state_d       = StHalt;
      mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBRt;
    alu_op        = AluAdd;
    pc_source     = PcAlu;
    ext_sel       = 1'b1;
    instr_done    = 1'b0;
`ifdef MCTL_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
`ifndef MCTL_ILLEGAL_TRAP_EN
        instr_done = !is_known_op(opcode);
`endif
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        mdr_write = mem_ready;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBRt;
        alu_op    = AluFunct;
      end
      StRWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        alu_op    = AluImm;
        ext_sel   = !is_logical_imm(opcode);
      end
      StIWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        ext_sel    = !is_logical_imm(opcode);
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SrcBRt;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = PcAluOut;
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = PcJump;
        instr_done = 1'b1;
      end
`ifdef MCTL_ILLEGAL_TRAP_EN
      StTrap: begin
        pc_write   = 1'b1;
        pc_source  = PcVector;
        illegal_op = 1'b1;
      end
`endif
      StHalt: ext_sel = 1'b0;
      default: ;
    endcase
  end

  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction cycle traces from a behavioural model, randomized stimulus.
module tb_multicycle_control;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_sel;
    logic       mem_timeout;
    logic       instr_done;
    logic       illegal_op;
  } out_t;

  typedef struct {
    bit         rdy;
    logic [5:0] op;
    bit         z;
    out_t       o;
  } cyc_t;

  typedef enum {KR, KLw, KSw, KBeq, KJ, KImm, KIll} kind_e;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_sel, mem_timeout, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op_w;

  multicycle_control #(
    .WAIT_LIMIT (16),
    .OP_W       (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mdr_write     (mdr_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .ext_sel       (ext_sel),
    .mem_timeout   (mem_timeout),
    .instr_done    (instr_done)
`ifdef MCTL_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op_w)
`endif
  );

`ifndef MCTL_ILLEGAL_TRAP_EN
  assign illegal_op_w = 1'b0;
`endif

  out_t act;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mdr_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                ext_sel, mem_timeout, instr_done, illegal_op_w};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t       q[$];
  logic [5:0] prev_op;
  bit         timed_out;
  int         force_zero;
  int         vectors;
  int         miscompares;

  function automatic bit rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic kind_e classify(input logic [5:0] op);
    kind_e k;
    case (op)
      OpR:                           k = KR;
      OpLw:                          k = KLw;
      OpSw:                          k = KSw;
      OpBeq:                         k = KBeq;
      OpJ:                           k = KJ;
      OpAddi, OpSlti, OpAndi, OpOri: k = KImm;
      default:                       k = KIll;
    endcase
    return k;
  endfunction

  function automatic out_t base();
    out_t o;
    o             = '0;
    o.ext_sel     = 1'b1;
    o.mem_timeout = timed_out;
    return o;
  endfunction

  task automatic push(input bit rdy, input logic [5:0] op, input out_t o);
    cyc_t c;
    c.rdy = rdy;
    c.op  = op;
    c.o   = o;
    c.z   = (force_zero < 0) ? rbit() : 1'(force_zero);
    q.push_back(c);
  endtask

  // Expected per-cycle outputs of one instruction: fw fetch stalls, mw data-memory stalls.
  task automatic model_instr(input logic [5:0] op, input int fw, input int mw);
    out_t  o;
    kind_e k;
    bit    se;
    k  = classify(op);
    se = !(op == OpAndi || op == OpOri);
    for (int i = 0; i < fw; i++) begin
      o = base(); o.mem_read = 1'b1; o.alu_src_b = 2'b01;
      push(1'b0, prev_op, o);
    end
    o = base(); o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(1'b1, prev_op, o);
    o = base(); o.alu_src_b = 2'b11;
    if (k == KIll) begin
`ifdef MCTL_ILLEGAL_TRAP_EN
      push(rbit(), op, o);
      o = base(); o.pc_write = 1'b1; o.pc_source = 2'b11; o.illegal_op = 1'b1;
      push(rbit(), op, o);
`else
      o.instr_done = 1'b1;
      push(rbit(), op, o);
`endif
    end else begin
      push(rbit(), op, o);
    end
    case (k)
      KLw, KSw: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        push(rbit(), op, o);
        o = base(); o.i_or_d = 1'b1;
        if (k == KLw) o.mem_read = 1'b1;
        else o.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, op, o);
        if (k == KLw) o.mdr_write = 1'b1;
        else o.instr_done = 1'b1;
        push(1'b1, op, o);
        if (k == KLw) begin
          o = base(); o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
          push(rbit(), op, o);
        end
      end
      KR: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_op = 2'b10;
        push(rbit(), op, o);
        o = base(); o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        push(rbit(), op, o);
      end
      KImm: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; o.ext_sel = se;
        push(rbit(), op, o);
        o = base(); o.reg_write = 1'b1; o.instr_done = 1'b1; o.ext_sel = se;
        push(rbit(), op, o);
      end
      KBeq: begin
        o = base(); o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
        o.pc_source = 2'b01; o.instr_done = 1'b1;
        push(rbit(), op, o);
      end
      KJ: begin
        o = base(); o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
        push(rbit(), op, o);
      end
      default: ;
    endcase
    prev_op = op;
  endtask

  // Starts and ends at a falling edge; drives, settles, compares, then advances a cycle.
  task automatic run_queue(input string name);
    cyc_t c;
    int   idx = 0;
    while (q.size() > 0) begin
      c         = q.pop_front();
      mem_ready = c.rdy;
      opcode    = c.op;
      zero      = c.z;
      #1;
      vectors++;
      if (act !== c.o) begin
        miscompares++;
        $display("FAIL %s cycle %0d: outputs %b, required %b", name, idx, act, c.o);
      end
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    model_instr(OpR, 2, 0);
    run_queue("reset");
  endtask

  task automatic test_rtype();
    model_instr(OpR, 0, 0);
    run_queue("rtype");
  endtask

  task automatic test_lw_waits();
    model_instr(OpLw, 3, 2);
    model_instr(OpSw, 1, 3);
    run_queue("lw_sw_waits");
  endtask

  task automatic test_ext_sel();
    model_instr(OpAndi, 0, 0);
    model_instr(OpAddi, 0, 0);
    model_instr(OpOri, 1, 0);
    model_instr(OpSlti, 0, 0);
    run_queue("ext_sel");
  endtask

  task automatic test_beq();
    force_zero = 1;
    model_instr(OpBeq, 0, 0);
    force_zero = 0;
    model_instr(OpBeq, 0, 0);
    force_zero = -1;
    model_instr(OpJ, 0, 0);
    run_queue("beq_j");
  endtask

  task automatic test_illegal();
    model_instr(6'b111111, 0, 0);
    model_instr(6'b010000, 1, 0);
    model_instr(OpR, 0, 0);
    run_queue("illegal");
  endtask

  // Reset lands after five stalled MEM_RD cycles; a cleared counter must allow 15 more stalls.
  task automatic test_reset_mid_wait();
    model_instr(OpLw, 0, 10);
    q = q[0:7];
    run_queue("mid_wait_pre");
    do_reset();
    model_instr(OpR, 15, 0);
    run_queue("mid_wait_post");
  endtask

  task automatic test_limit_ready();
    model_instr(OpSw, 15, 15);
    model_instr(OpLw, 15, 15);
    run_queue("limit_ready");
  endtask

  task automatic test_random();
    logic [5:0] op;
    int         sel;
    int         fw, mw;
    logic [5:0] ops [9] = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpSlti, OpAndi, OpOri};
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(9, 0));
      if (sel < 9) begin
        op = ops[sel];
      end else begin
        op = 6'($urandom);
        if (classify(op) != KIll) op = 6'b111110;
      end
      fw = ($urandom_range(7, 0) == 7) ? 15 : int'($urandom_range(3, 0));
      mw = ($urandom_range(7, 0) == 7) ? 15 : int'($urandom_range(3, 0));
      model_instr(op, fw, mw);
    end
    run_queue("random");
  endtask

  task automatic test_timeout();
    out_t o;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      o = base(); o.mem_read = 1'b1; o.alu_src_b = 2'b01;
      push(1'b0, prev_op, o);
    end
    timed_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      o = '0; o.mem_timeout = 1'b1;
      push(rbit(), 6'($urandom), o);
    end
    run_queue("timeout");
    timed_out = 1'b0;
    do_reset();
    model_instr(OpJ, 0, 0);
    run_queue("recover");
  endtask

  initial begin
    reset       = 1'b1;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    opcode      = OpAndi;
    prev_op     = OpAndi;
    timed_out   = 1'b0;
    force_zero  = -1;
    vectors     = 0;
    miscompares = 0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_lw_waits();
    test_ext_sel();
    test_beq();
    test_illegal();
    test_reset_mid_wait();
    test_limit_ready();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the 32-bit multi-cycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Drives every datapath mux/enable, including the immediate extender mode (sign vs zero).
- Sits beside the register file, ALU, sign/zero extender and unified memory port; stalls on memory via a ready handshake.

Parameters:
- WAIT_LIMIT, 16, maximum cycles a memory state may wait for mem_ready before faulting.
- OP_W, 6, opcode field width (instr[31:26]).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  OP_W  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1
- i_or_d  out  1  0=PC address, 1=ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mdr_write  out  1  load memory data register
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=extended imm, 11=extended imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded, 11=opcode-decoded immediate op
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ext_sel  out  1  1=sign-extend, 0=zero-extend immediate
- mem_timeout  out  1  sticky fault flag
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000, SLTI=001010, ANDI=001100, ORI=001101.
- ext_sel=0 for ANDI/ORI; ext_sel=1 otherwise, including in FETCH and DECODE.
- States and transitions:
  - FETCH → DECODE.
  - DECODE → MEM_ADDR (LW/SW), R_EXEC (R), I_EXEC (ADDI/SLTI/ANDI/ORI), BRANCH (BEQ), JUMP (J), else ILLEGAL handling.
  - MEM_ADDR → MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD → MEM_WB.
  - R_EXEC → R_WB.
  - I_EXEC → I_WB.
  - MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP → FETCH.
  - HALT is absorbing until reset.
- Memory handshake:
  - FETCH, MEM_RD and MEM_WR hold mem_read or mem_write high and remain in state until mem_ready=1.
  - In FETCH, ir_write and pc_write (alu_src_a=0, alu_src_b=01, pc_source=00, alu_op=00) assert only in the mem_ready=1 cycle.
  - In MEM_RD, mdr_write asserts only with mem_ready=1.
  - In MEM_WR, instr_done asserts only with mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
- R_WB: reg_dst=1, reg_write=1.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11 (ADDI may use 00).
- I_WB: reg_dst=0, reg_write=1.
- MEM_WB: mem_to_reg=1, reg_write=1, reg_dst=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- instr_done pulses in MEM_WB, R_WB, I_WB, BRANCH, JUMP, and the completing MEM_WR cycle.
- Wait counter:
  - Counts consecutive cycles in a memory state with mem_ready=0 and clears on state exit.
  - On reaching WAIT_LIMIT: mem_timeout is set (sticky) and next state is HALT.
  - A mem_ready that arrives in the limit cycle wins; no fault is raised.
- HALT: all outputs 0 except mem_timeout.
- Reset:
  - reset=1 at an edge forces FETCH, counter=0, mem_timeout=0, from any state including mid-wait.
  - Reset takes priority over all transitions.
  - Post-reset outputs: mem_read=1, alu_src_b=01, ext_sel=1; every other output 0 until mem_ready.
- Outputs are combinational from the registered state plus mem_ready/zero only; opcode affects next state and ext_sel only.

Optional Feature:
- Macro: MCTL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP pulses illegal_op (extra 1-bit output port) for one cycle with pc_write=1, pc_source=11 (exception vector).
  - TRAP → FETCH.
- Undefined:
  - An unknown opcode is a NOP: DECODE → FETCH with instr_done=1.
  - No illegal_op port exists.

Decomposition:
- Package mctl_pkg holds:
  - opcode constants;
  - state encoding localparams (4 bits);
  - alu_op, alu_src_b and pc_source encodings, shared with the ALU control and datapath muxes.
- One natural sub-module, mctl_wait_timer: counter, clear and limit compare.

Test Plan:
- Reset mid-MEM_RD wait (counter=5) → next cycle state=FETCH, mem_read=1, counter=0, mem_timeout=0.
- R-type, mem_ready tied 1 → 4 cycles FETCH/DECODE/R_EXEC/R_WB; reg_dst=1, reg_write=1 in cycle 4; instr_done pulse.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEM_RD → 10 cycles total; mdr_write only on the ready cycle.
- ANDI (001100) → ext_sel=0 in I_EXEC; ADDI (001000) → ext_sel=1.
- BEQ with zero=1, then zero=0 → pc_write_cond=1 both times, 3 cycles each.
- mem_ready held 0 in FETCH with WAIT_LIMIT=16 → mem_timeout=1 after 16 cycles, then HALT with all other outputs 0; opcode 111111 with MCTL_ILLEGAL_TRAP_EN → illegal_op pulse, pc_source=11.
